// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU/memory datum, commits GPR and HI/LO writes, serves bypassed reads.
// Write latency 1 cycle to storage, 0 cycles to read ports; no backpressure, every writeback commits.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteReg_WB,
  input  logic [ADDR_W-1:0] target_WB,
  input  logic              MemOrAlu_WB,
  input  logic [DATA_W-1:0] ALU_data_WB,
  input  logic [DATA_W-1:0] MEM_data_WB,
  input  logic              we_hi_WB,
  input  logic              we_lo_WB,
  input  logic [DATA_W-1:0] hi_WB,
  input  logic [DATA_W-1:0] lo_WB,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] wb_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] gpr_q [DEPTH];
  logic [DATA_W-1:0] gpr_d [DEPTH];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              gpr_wr;

  assign wb_data = MemOrAlu_WB ? MEM_data_WB : ALU_data_WB;
  assign gpr_wr  = WriteReg_WB && (target_WB != '0);

  always_comb begin
    gpr_d = gpr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (gpr_wr) gpr_d[target_WB] = wb_data;
    if (we_hi_WB) hi_d = hi_WB;
    if (we_lo_WB) lo_d = lo_WB;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) gpr_q[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Address 0 never bypasses, so a discarded write to $zero cannot leak onto a read port.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    hi_o   = '0;
    lo_o   = '0;
    if (rst) begin
      if (raddr1 != '0) rdata1 = (gpr_wr && target_WB == raddr1) ? wb_data : gpr_q[raddr1];
      if (raddr2 != '0) rdata2 = (gpr_wr && target_WB == raddr2) ? wb_data : gpr_q[raddr2];
      hi_o = we_hi_WB ? hi_WB : hi_q;
      lo_o = we_lo_WB ? lo_WB : lo_q;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized plus directed bench for wb_regfile with a queue-based scoreboard and array reference model.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          WriteReg_WB = 1'b0, MemOrAlu_WB = 1'b0, we_hi_WB = 1'b0, we_lo_WB = 1'b0;
  logic [AW-1:0] target_WB = '0, raddr1 = '0, raddr2 = '0;
  logic [DW-1:0] ALU_data_WB = '0, MEM_data_WB = '0, hi_WB = '0, lo_WB = '0;
  logic [DW-1:0] rdata1, rdata2, hi_o, lo_o, wb_data;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .WriteReg_WB(WriteReg_WB), .target_WB(target_WB),
    .MemOrAlu_WB(MemOrAlu_WB), .ALU_data_WB(ALU_data_WB), .MEM_data_WB(MEM_data_WB),
    .we_hi_WB(we_hi_WB), .we_lo_WB(we_lo_WB), .hi_WB(hi_WB), .lo_WB(lo_WB),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [DW-1:0] r1, r2, hi, lo, wb;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_gpr [32];
  logic [DW-1:0] m_hi, m_lo;
  int            n_chk = 0;
  int            n_pass = 0;
  int            cyc = 0;

  task automatic chk(input string nm, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, act, exp);
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rdata1",  e.cyc, rdata1,  e.r1);
        chk("rdata2",  e.cyc, rdata2,  e.r2);
        chk("hi_o",    e.cyc, hi_o,    e.hi);
        chk("lo_o",    e.cyc, lo_o,    e.lo);
        chk("wb_data", e.cyc, wb_data, e.wb);
      end
    end
  end

  function automatic logic [DW-1:0] model_read(input logic r, input logic we, input int tgt,
                                               input int a, input logic [DW-1:0] wb);
    if (!r || a == 0) return '0;
    if (we && tgt == a) return wb;
    return m_gpr[a];
  endfunction

  task automatic step(input logic r, input logic we, input int tgt, input logic sel,
                      input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                      input logic whi, input logic [DW-1:0] hv,
                      input logic wlo, input logic [DW-1:0] lv,
                      input int a1, input int a2);
    exp_t          e;
    logic [DW-1:0] wb;
    @(posedge clk);
    #1;
    rst = r; WriteReg_WB = we; target_WB = AW'(tgt); MemOrAlu_WB = sel;
    ALU_data_WB = alu; MEM_data_WB = mem; we_hi_WB = whi; hi_WB = hv;
    we_lo_WB = wlo; lo_WB = lv; raddr1 = AW'(a1); raddr2 = AW'(a2);
    wb = sel ? mem : alu;
    e.cyc = cyc;
    e.wb  = wb;
    e.r1  = model_read(r, we, tgt, a1, wb);
    e.r2  = model_read(r, we, tgt, a2, wb);
    e.hi  = !r ? '0 : (whi ? hv : m_hi);
    e.lo  = !r ? '0 : (wlo ? lv : m_lo);
    sb_q.push_back(e);
    // State the DUT will hold after the coming edge.
    if (!r) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      if (we && tgt != 0) m_gpr[tgt] = wb;
      if (whi) m_hi = hv;
      if (wlo) m_lo = lv;
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi = '0;
    m_lo = '0;

    // reset holds off a pending write
    step(0, 1, 5, 0, 32'h1234, 0, 1, 32'h99, 1, 32'h98, 5, 5);
    step(0, 1, 5, 0, 32'h1234, 0, 1, 32'h99, 1, 32'h98, 5, 5);
    step(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    // memory select, bypass then storage
    step(1, 1, 3, 1, 32'h1, 32'hDEADBEEF, 0, 0, 0, 0, 3, 5);
    step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    // $zero
    step(1, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // dual bypass, neighbour unaffected
    step(1, 1, 8, 0, 32'h00000088, 0, 0, 0, 0, 0, 8, 0);
    step(1, 1, 7, 0, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 7, 7);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 8);
    // HI/LO alongside a GPR write
    step(1, 1, 9, 0, 32'h9, 0, 1, 32'h11, 1, 32'h22, 9, 0);
    step(1, 0, 0, 0, 0, 0, 1, 32'h33, 0, 32'h77, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    // last write wins
    step(1, 1, 10, 0, 32'h1, 0, 0, 0, 0, 0, 10, 0);
    step(1, 1, 10, 1, 32'h5, 32'h2, 0, 0, 0, 0, 10, 10);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 9);
    // reset mid-stream drops HI write
    step(1, 0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 0);
    step(0, 1, 4, 0, 32'h44, 0, 1, 32'h55, 0, 0, 10, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 4);

    for (int k = 0; k < 400; k++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0),
           narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), $urandom, $urandom,
           ($urandom_range(0, 3) == 0), $urandom,
           ($urandom_range(0, 3) == 0), $urandom,
           narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31)),
           narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31)));
    end

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain cycle=%0d got=%0d pending expected=0 pending", cyc, sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
